// File: rtl/vpu_pkg.sv
// Shared opcodes, header field positions, error codes and dispatcher state encoding.
package vpu_pkg;

    localparam logic [3:0] CRT       = 4'd0;
    localparam logic [3:0] DEL       = 4'd1;
    localparam logic [3:0] DEL_ALL   = 4'd2;
    localparam logic [3:0] TRANS_ONE = 4'd3;
    localparam logic [3:0] TRANS     = 4'd4;
    localparam logic [3:0] ROTL      = 4'd6;
    localparam logic [3:0] ROTR      = 4'd7;
    localparam logic [3:0] SCALE     = 4'd8;

    localparam int HDR_OP_LSB    = 28;
    localparam int HDR_CODE_LSB  = 24;
    localparam int HDR_NUM_LSB   = 19;
    localparam int HDR_TYPE_LSB  = 17;
    localparam int HDR_COLOR_LSB = 9;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] ERR_MEM_FULL   = 2'd2;

    localparam int CMD_W       = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OPS       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] code;
        logic [4:0] num;
        logic [1:0] typ;
        logic [7:0] color;
    } hdr_t;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            CRT, DEL, DEL_ALL, TRANS_ONE, TRANS, ROTL, ROTR, SCALE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] op_words(input logic [3:0] op);
        logic [2:0] n;
        case (op)
            CRT:              n = 3'd4;
            TRANS_ONE, TRANS: n = 3'd1;
            default:          n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Generic synchronous FIFO; pop data is the head entry, visible combinationally.
// Pushes are ignored when full and pops when empty; simultaneous push/pop keeps occupancy.
module vpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_cmd_dispatcher.sv
// Decodes host command words from a 4-deep FIFO and drives the matrix_unit command bus.
// go appears 2 cycles after a 0-operand header pop; cmd_ready drops only when the FIFO is full.
module vpu_cmd_dispatcher
    import vpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic               go,
    output logic [1:0]         obj_type,
    output logic [7:0]         obj_color,
    output logic [4:0]         obj_num_in,
    output logic [3:0]         gmt_op,
    output logic [3:0]         gmt_code,
    output logic signed [15:0] v0,
    output logic signed [15:0] v1,
    output logic signed [15:0] v2,
    output logic signed [15:0] v3,
    output logic signed [15:0] v4,
    output logic signed [15:0] v5,
    output logic signed [15:0] v6,
    output logic signed [15:0] v7,
    input  logic               busy,
    input  logic               obj_mem_full,
    output logic               cmd_done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               disp_busy
);
    state_t             state;
    state_t             state_nxt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;
    logic [CMD_W-1:0]   fifo_dat;
    hdr_t               head_hdr;
    hdr_t               hdr_q;
    logic               drop_q;
    logic [2:0]         ops_left;
    logic [1:0]         ops_idx;
    logic [3:0]         ack_cnt;
    logic signed [15:0] stage_v [8];
    logic signed [15:0] v_q [8];
    logic               done;
    logic               err_set;
    logic [1:0]         err_code_nxt;

    vpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_valid && cmd_ready),
        .push_dat (cmd_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        head_hdr       = '0;
        head_hdr.op    = fifo_dat[HDR_OP_LSB +: 4];
        head_hdr.code  = fifo_dat[HDR_CODE_LSB +: 4];
        head_hdr.num   = fifo_dat[HDR_NUM_LSB +: 5];
        head_hdr.typ   = fifo_dat[HDR_TYPE_LSB +: 2];
        head_hdr.color = fifo_dat[HDR_COLOR_LSB +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fifo_pop     = 1'b0;
        done         = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = ERR_NONE;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!op_legal(head_hdr.op)) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_ILLEGAL_OP;
                    end else if (op_words(head_hdr.op) != 3'd0) begin
                        state_nxt = OPS;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            OPS: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (ops_left == 3'd1) begin
                        // A create refused for lack of object memory still drains its operands.
                        if (drop_q) begin
                            err_set      = 1'b1;
                            err_code_nxt = ERR_MEM_FULL;
                            state_nxt    = IDLE;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end
            end
            ISSUE: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == 4'(ACK_TIMEOUT)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            go         <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            hdr_q      <= '0;
            drop_q     <= 1'b0;
            ops_left   <= '0;
            ops_idx    <= '0;
            ack_cnt    <= '0;
            gmt_op     <= '0;
            gmt_code   <= '0;
            obj_num_in <= '0;
            obj_type   <= '0;
            obj_color  <= '0;
            for (int i = 0; i < 8; i++) begin
                stage_v[i] <= '0;
                v_q[i]     <= '0;
            end
        end else begin
            go       <= (state == ISSUE);
            err      <= err_set;
            err_code <= err_code_nxt;
            if (state == IDLE && fifo_pop) begin
                hdr_q    <= head_hdr;
                ops_left <= op_words(head_hdr.op);
                ops_idx  <= '0;
                drop_q   <= (head_hdr.op == CRT) && obj_mem_full;
            end
            if (state == OPS && fifo_pop) begin
                ops_left <= ops_left - 3'd1;
                ops_idx  <= ops_idx + 2'd1;
                if (hdr_q.op == CRT) begin
                    stage_v[{ops_idx, 1'b0}] <= $signed(fifo_dat[31:16]);
                    stage_v[{ops_idx, 1'b1}] <= $signed(fifo_dat[15:0]);
                end else begin
                    stage_v[0] <= $signed(fifo_dat[15:0]);
                end
            end
            if (state == ISSUE) begin
                gmt_op     <= hdr_q.op;
                gmt_code   <= hdr_q.code;
                obj_num_in <= hdr_q.num;
                obj_type   <= hdr_q.typ;
                obj_color  <= hdr_q.color;
                ack_cnt    <= '0;
                if (hdr_q.op == CRT) begin
                    for (int i = 0; i < 8; i++) begin
                        v_q[i] <= stage_v[i];
                    end
                end else if (hdr_q.op == TRANS_ONE || hdr_q.op == TRANS) begin
                    v_q[0] <= stage_v[0];
                end
            end else if (state == WAIT_ACK) begin
                ack_cnt <= ack_cnt + 4'd1;
            end
        end
    end

    assign cmd_ready = !fifo_full;
    assign cmd_done  = done && !rst;
    assign disp_busy = !rst && (!fifo_empty || state != IDLE);

    assign v0 = v_q[0];
    assign v1 = v_q[1];
    assign v2 = v_q[2];
    assign v3 = v_q[3];
    assign v4 = v_q[4];
    assign v5 = v_q[5];
    assign v6 = v_q[6];
    assign v7 = v_q[7];

endmodule

// File: tb/tb_vpu_cmd_dispatcher.sv
// Directed self-checking bench for vpu_cmd_dispatcher.
module tb_vpu_cmd_dispatcher;

    localparam int W_GO   = 0;
    localparam int W_DONE = 1;
    localparam int W_ERR  = 2;

    logic               clk;
    logic               rst;
    logic [31:0]        cmd_data;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               go;
    logic [1:0]         obj_type;
    logic [7:0]         obj_color;
    logic [4:0]         obj_num_in;
    logic [3:0]         gmt_op;
    logic [3:0]         gmt_code;
    logic signed [15:0] v_o [8];
    logic               busy;
    logic               obj_mem_full;
    logic               cmd_done;
    logic               err;
    logic [1:0]         err_code;
    logic               disp_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int go_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [3:0] go_codes [$];

    vpu_cmd_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .go           (go),
        .obj_type     (obj_type),
        .obj_color    (obj_color),
        .obj_num_in   (obj_num_in),
        .gmt_op       (gmt_op),
        .gmt_code     (gmt_code),
        .v0           (v_o[0]),
        .v1           (v_o[1]),
        .v2           (v_o[2]),
        .v3           (v_o[3]),
        .v4           (v_o[4]),
        .v5           (v_o[5]),
        .v6           (v_o[6]),
        .v7           (v_o[7]),
        .busy         (busy),
        .obj_mem_full (obj_mem_full),
        .cmd_done     (cmd_done),
        .err          (err),
        .err_code     (err_code),
        .disp_busy    (disp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (go === 1'b1) begin
            go_cnt++;
            go_codes.push_back(gmt_code);
        end
        if (cmd_done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig_hi(input int which);
        case (which)
            W_GO:    return go === 1'b1;
            W_DONE:  return cmd_done === 1'b1;
            default: return err === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, output int cyc);
        cyc = 0;
        while (!sig_hi(which) && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: cmd_ready=%b required 1 for word %h", cmd_ready, w);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (go !== 1'b0 || cmd_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: go=%b done=%b err=%b required 0", go, cmd_done, err); end
        n_checks++; if (err_code !== 2'd0 || disp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_status: err_code=%0d disp_busy=%b required 0", err_code, disp_busy); end
        n_checks++; if (gmt_op !== 4'd0 || gmt_code !== 4'd0 || obj_type !== 2'd0 || obj_color !== 8'd0 || obj_num_in !== 5'd0) begin n_fail++; $display("FAIL reset_bus: op=%0d code=%0d type=%0d color=%0d num=%0d required 0", gmt_op, gmt_code, obj_type, obj_color, obj_num_in); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (v_o[i] !== 16'sd0) begin n_fail++; $display("FAIL reset_v%0d: got %0d required 0", i, v_o[i]); end
        end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rotate();
        int g0, d0;
        g0 = go_cnt;
        d0 = done_cnt;
        push_word(32'h7A00_0000);
        n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL rot_go_pop_cycle: go=%b required 0", go); end
        tick();
        n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL rot_go_issue_cycle: go=%b required 0", go); end
        tick();
        n_checks++; if (go !== 1'b1) begin n_fail++; $display("FAIL rot_go_latency: go=%b required 1", go); end
        n_checks++; if (gmt_op !== 4'd7 || gmt_code !== 4'hA) begin n_fail++; $display("FAIL rot_fields: op=%0d code=%h required 7/a", gmt_op, gmt_code); end
        tick();
        n_checks++; if (go !== 1'b0) begin n_fail++; $display("FAIL rot_go_width: go=%b required 0", go); end
        tick();
        busy = 1'b1;
        repeat (4) tick();
        n_checks++; if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL rot_done_early: cmd_done=%b required 0", cmd_done); end
        tick();
        busy = 1'b0;
        #1;
        n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL rot_done_on_fall: cmd_done=%b required 1", cmd_done); end
        tick();
        n_checks++; if (cmd_done !== 1'b0 || disp_busy !== 1'b0) begin n_fail++; $display("FAIL rot_after: cmd_done=%b disp_busy=%b required 0/0", cmd_done, disp_busy); end
        n_checks++; if (go_cnt - g0 != 1 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL rot_counts: go=%0d done=%0d required 1/1", go_cnt - g0, done_cnt - d0); end
    endtask

    task automatic test_create();
        int cyc;
        logic signed [15:0] exp_v [8];
        exp_v = '{16'sd100, 16'sd100, 16'sd100, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd100};
        push_word(32'h0007_FE00);
        push_word(32'h0064_0064);
        push_word(32'h0064_00C8);
        push_word(32'h00C8_00C8);
        push_word(32'h00C8_0064);
        wait_for(W_GO, 20, cyc);
        n_checks++; if (go !== 1'b1) begin n_fail++; $display("FAIL crt_go: go=%b required 1", go); end
        n_checks++; if (gmt_op !== 4'd0 || obj_type !== 2'd3 || obj_color !== 8'hFF) begin n_fail++; $display("FAIL crt_fields: op=%0d type=%0d color=%h required 0/3/ff", gmt_op, obj_type, obj_color); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (v_o[i] !== exp_v[i]) begin n_fail++; $display("FAIL crt_v%0d: got %0d required %0d", i, v_o[i], exp_v[i]); end
        end
        wait_for(W_DONE, 20, cyc);
        n_checks++; if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL crt_done: cmd_done=%b required 1", cmd_done); end
        tick();
    endtask

    task automatic test_create_full();
        int cyc, g0, e0;
        g0 = go_cnt;
        e0 = err_cnt;
        obj_mem_full = 1'b1;
        push_word(32'h0007_FE00);
        push_word(32'h1111_2222);
        push_word(32'h3333_4444);
        push_word(32'h5555_6666);
        push_word(32'h7777_0888);
        wait_for(W_ERR, 20, cyc);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL full_err: err=%b err_code=%0d required 1/2", err, err_code); end
        n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL full_drained: disp_busy=%b required 0", disp_busy); end
        obj_mem_full = 1'b0;
        repeat (12) tick();
        n_checks++; if (go_cnt != g0 || err_cnt - e0 != 1) begin n_fail++; $display("FAIL full_counts: go=%0d err=%0d required 0/1", go_cnt - g0, err_cnt - e0); end
        n_checks++; if (v_o[3] !== 16'sd200) begin n_fail++; $display("FAIL full_v_kept: v3=%0d required 200", v_o[3]); end
    endtask

    task automatic test_illegal();
        int cyc, e0;
        e0 = err_cnt;
        push_word(32'h5000_0000);
        push_word(32'h1000_0000);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL ill_err: err=%b err_code=%0d required 1/1", err, err_code); end
        tick();
        n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL ill_err_width: err=%b err_code=%0d required 0/0", err, err_code); end
        wait_for(W_GO, 10, cyc);
        n_checks++; if (go !== 1'b1 || gmt_op !== 4'd1) begin n_fail++; $display("FAIL ill_next_issue: go=%b op=%0d required 1/1", go, gmt_op); end
        wait_for(W_DONE, 20, cyc);
        tick();
        n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL ill_err_count: got %0d required 1", err_cnt - e0); end
    endtask

    task automatic test_translate();
        int cyc;
        push_word(32'h3000_0000);
        push_word(32'h1234_FFF6);
        wait_for(W_GO, 20, cyc);
        n_checks++; if (go !== 1'b1 || gmt_op !== 4'd3) begin n_fail++; $display("FAIL trn_go: go=%b op=%0d required 1/3", go, gmt_op); end
        n_checks++; if (v_o[0] !== -16'sd10) begin n_fail++; $display("FAIL trn_v0: got %0d required -10", v_o[0]); end
        n_checks++; if (v_o[1] !== 16'sd100 || v_o[7] !== 16'sd100) begin n_fail++; $display("FAIL trn_v_kept: v1=%0d v7=%0d required 100/100", v_o[1], v_o[7]); end
        wait_for(W_DONE, 20, cyc);
        tick();
    endtask

    task automatic test_ack_timeout();
        int cyc;
        push_word(32'h2000_0000);
        wait_for(W_GO, 20, cyc);
        n_checks++; if (go !== 1'b1) begin n_fail++; $display("FAIL tmo_go: go=%b required 1", go); end
        tick();
        wait_for(W_DONE, 30, cyc);
        n_checks++; if (cmd_done !== 1'b1 || cyc != 7) begin n_fail++; $display("FAIL tmo_done_delay: cmd_done=%b after %0d cycles from go, required 1 after 8", cmd_done, cyc + 1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, acc, q0, n;
        bit take;
        logic [31:0] words [5];
        words = '{32'h1100_0000, 32'h1200_0000, 32'h1300_0000, 32'h1400_0000, 32'h1500_0000};
        busy = 1'b1;
        push_word(32'h8000_0000);
        wait_for(W_GO, 20, cyc);
        tick();
        q0 = go_codes.size();
        acc = 0;
        cmd_valid = 1'b1;
        cmd_data = words[0];
        for (int i = 0; i < 8; i++) begin
            take = (cmd_ready === 1'b1);
            tick();
            if (take) acc++;
            if (acc < 5) cmd_data = words[acc];
        end
        n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d words required 4", acc); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: cmd_ready=%b required 0", cmd_ready); end
        cmd_valid = 1'b0;
        busy = 1'b0;
        n = 0;
        while ((go_codes.size() < q0 + 4 || disp_busy !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        repeat (15) tick();
        n_checks++; if (go_codes.size() != q0 + 4) begin n_fail++; $display("FAIL bp_go_count: got %0d required 4", go_codes.size() - q0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q0 + i >= go_codes.size()) begin
                n_fail++; $display("FAIL bp_order%0d: missing issue, required code %0d", i, i + 1);
            end else if (go_codes[q0 + i] !== 4'(i + 1)) begin
                n_fail++; $display("FAIL bp_order%0d: got code %0d required %0d", i, go_codes[q0 + i], i + 1);
            end
        end
    endtask

    task automatic test_reset_wait_done();
        int cyc, d0;
        busy = 1'b1;
        push_word(32'h6000_0000);
        wait_for(W_GO, 20, cyc);
        repeat (2) tick();
        n_checks++; if (disp_busy !== 1'b1 || gmt_op !== 4'd6) begin n_fail++; $display("FAIL rwd_in_cmd: disp_busy=%b op=%0d required 1/6", disp_busy, gmt_op); end
        d0 = done_cnt;
        rst = 1'b1;
        busy = 1'b0;
        tick();
        n_checks++; if (go !== 1'b0 || cmd_done !== 1'b0 || err !== 1'b0 || disp_busy !== 1'b0) begin n_fail++; $display("FAIL rwd_pulses: go=%b done=%b err=%b disp_busy=%b required 0", go, cmd_done, err, disp_busy); end
        n_checks++; if (gmt_op !== 4'd0 || v_o[0] !== 16'sd0 || v_o[1] !== 16'sd0) begin n_fail++; $display("FAIL rwd_bus: op=%0d v0=%0d v1=%0d required 0", gmt_op, v_o[0], v_o[1]); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rwd_ready: cmd_ready=%b required 1", cmd_ready); end
        tick();
        rst = 1'b0;
        repeat (12) tick();
        n_checks++; if (done_cnt != d0 || disp_busy !== 1'b0) begin n_fail++; $display("FAIL rwd_no_done: done=%0d disp_busy=%b required 0/0", done_cnt - d0, disp_busy); end
    endtask

    initial begin
        rst          = 1'b1;
        cmd_data     = '0;
        cmd_valid    = 1'b0;
        busy         = 1'b0;
        obj_mem_full = 1'b0;
        test_reset();
        test_rotate();
        test_create();
        test_create_full();
        test_illegal();
        test_translate();
        test_ack_timeout();
        test_back_to_back();
        test_reset_wait_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
